// File: rtl/fabric_ingress_arbiter.sv
// fabric_ingress_arbiter: round-robin scheduler that shares the fabric
// forwarding path among NUM_PORTS ingress RX FIFOs. Grants one ready port,
// latches its headers, requests its data, streams the words onto a single
// output bus, then pops the frame and rotates priority.
//
// Ports:
//   fabric_clk, rst_n         clock, asynchronous active-low reset
//   port_frame_valid          per-port frame ready
//   port_dst_mac/src_mac/vlan per-port headers, port i at [W*i +: W]
//   port_fwd_en               one-cycle one-hot forward request
//   port_fwd_valid/bytes/data per-port data word stream
//   port_pop                  one-cycle one-hot frame pop
//   out_ready                 downstream can take a new frame (sampled in IDLE)
//   out_start/out_port/hdrs   frame start pulse, source port, latched headers
//   out_valid/bytes/data      forwarded data word
//   out_end/out_abort         frame complete / aborted on forward timeout
module fabric_ingress_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned FWD_TIMEOUT = 15,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic                         fabric_clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         port_frame_valid,
  input  logic [48*NUM_PORTS-1:0]      port_dst_mac,
  input  logic [48*NUM_PORTS-1:0]      port_src_mac,
  input  logic [12*NUM_PORTS-1:0]      port_vlan,
  output logic [NUM_PORTS-1:0]         port_fwd_en,
  input  logic [NUM_PORTS-1:0]         port_fwd_valid,
  input  logic [4*NUM_PORTS-1:0]       port_fwd_bytes_valid,
  input  logic [64*NUM_PORTS-1:0]      port_fwd_data,
  output logic [NUM_PORTS-1:0]         port_pop,
  input  logic                         out_ready,
  output logic                         out_start,
  output logic [$clog2(NUM_PORTS)-1:0] out_port,
  output logic [47:0]                  out_dst_mac,
  output logic [47:0]                  out_src_mac,
  output logic [11:0]                  out_vlan,
  output logic                         out_valid,
  output logic [3:0]                   out_bytes_valid,
  output logic [63:0]                  out_data,
  output logic                         out_end,
  output logic                         out_abort
);

  localparam int unsigned PW   = $clog2(NUM_PORTS);
  localparam int unsigned CMAX = (FWD_TIMEOUT > HOLDOFF) ? FWD_TIMEOUT : HOLDOFF;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, WAIT, STREAM, POP, HOLD} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [PW-1:0]          rr_ptr, rr_ptr_d;
  logic [NUM_PORTS-1:0]   fwd_en_d, pop_d;
  logic                   start_d, end_d, abort_d, valid_d;
  logic [PW-1:0]          port_d;
  logic [47:0]            dst_d, src_d;
  logic [11:0]            vlan_d;
  logic [3:0]             bytes_d;
  logic [63:0]            data_d;
  logic                   found;
  logic [PW-1:0]          sel, cand;
  int unsigned            sbase, gbase;

  // (base + off) modulo NUM_PORTS, valid for off < NUM_PORTS
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  assign sbase = 32'(sel);
  assign gbase = 32'(out_port);

  // First ready port at or above rr_ptr, searching modulo NUM_PORTS
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = wrap_add(rr_ptr, i);
      if (!found && port_frame_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rr_ptr_d = rr_ptr;
    fwd_en_d = '0;
    pop_d    = '0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    abort_d  = 1'b0;
    valid_d  = 1'b0;
    bytes_d  = '0;
    data_d   = '0;
    port_d   = out_port;
    dst_d    = out_dst_mac;
    src_d    = out_src_mac;
    vlan_d   = out_vlan;
    case (state)
      IDLE: begin
        if (out_ready && found) begin
          fwd_en_d = NUM_PORTS'(1) << sel;
          start_d  = 1'b1;
          port_d   = sel;
          dst_d    = port_dst_mac[sbase*48 +: 48];
          src_d    = port_src_mac[sbase*48 +: 48];
          vlan_d   = port_vlan[sbase*12 +: 12];
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (port_fwd_valid[out_port]) begin
          valid_d = 1'b1;
          bytes_d = port_fwd_bytes_valid[gbase*4 +: 4];
          data_d  = port_fwd_data[gbase*64 +: 64];
          state_d = STREAM;
        end else if (cnt >= CW'(FWD_TIMEOUT - 1)) begin
          // counter parks at FWD_TIMEOUT rather than wrapping
          abort_d = 1'b1;
          cnt_d   = CW'(FWD_TIMEOUT);
          state_d = POP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STREAM: begin
        // frames are contiguous: the first gap terminates the frame
        if (port_fwd_valid[out_port]) begin
          valid_d = 1'b1;
          bytes_d = port_fwd_bytes_valid[gbase*4 +: 4];
          data_d  = port_fwd_data[gbase*64 +: 64];
        end else begin
          end_d   = 1'b1;
          state_d = POP;
        end
      end
      POP: begin
        pop_d    = NUM_PORTS'(1) << out_port;
        rr_ptr_d = wrap_add(out_port, 1);
        cnt_d    = '0;
        state_d  = (HOLDOFF == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        // give the popped port time to refresh its frame_valid
        if (cnt >= CW'(HOLDOFF - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge fabric_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rr_ptr          <= '0;
      port_fwd_en     <= '0;
      port_pop        <= '0;
      out_start       <= 1'b0;
      out_port        <= '0;
      out_dst_mac     <= '0;
      out_src_mac     <= '0;
      out_vlan        <= '0;
      out_valid       <= 1'b0;
      out_bytes_valid <= '0;
      out_data        <= '0;
      out_end         <= 1'b0;
      out_abort       <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      rr_ptr          <= rr_ptr_d;
      port_fwd_en     <= fwd_en_d;
      port_pop        <= pop_d;
      out_start       <= start_d;
      out_port        <= port_d;
      out_dst_mac     <= dst_d;
      out_src_mac     <= src_d;
      out_vlan        <= vlan_d;
      out_valid       <= valid_d;
      out_bytes_valid <= bytes_d;
      out_data        <= data_d;
      out_end         <= end_d;
      out_abort       <= abort_d;
    end
  end

endmodule

// File: tb/tb_fabric_ingress_arbiter.sv
// tb_fabric_ingress_arbiter: directed stimulus with a scoreboard. Each test
// queues its hand-derived event sequence (start, words, end/abort, pop) with
// expected cycle spacing; a monitor pops and compares on every DUT event.
// A behavioural port model holds per-port frame queues and answers
// port_fwd_en one cycle later with the frame's words.
module tb_fabric_ingress_arbiter;

  localparam int NP      = 4;
  localparam int TIMEOUT = 15;
  localparam int K_START = 0;
  localparam int K_WORD  = 1;
  localparam int K_END   = 2;
  localparam int K_ABORT = 3;
  localparam int K_POP   = 4;

  typedef struct {
    int kind;
    int port;
    int tag;
    int idx;
    int nw;
    int lb;
    int gap;
    int at;
  } ev_t;

  ev_t sb[$];

  logic              fabric_clk = 1'b0;
  logic              rst_n;
  logic              out_ready;
  logic [NP-1:0]     port_frame_valid     = '0;
  logic [48*NP-1:0]  port_dst_mac         = '0;
  logic [48*NP-1:0]  port_src_mac         = '0;
  logic [12*NP-1:0]  port_vlan            = '0;
  logic [NP-1:0]     port_fwd_valid       = '0;
  logic [4*NP-1:0]   port_fwd_bytes_valid = '0;
  logic [64*NP-1:0]  port_fwd_data        = '0;
  logic [NP-1:0]     port_fwd_en;
  logic [NP-1:0]     port_pop;
  logic              out_start;
  logic [1:0]        out_port;
  logic [47:0]       out_dst_mac;
  logic [47:0]       out_src_mac;
  logic [11:0]       out_vlan;
  logic              out_valid;
  logic [3:0]        out_bytes_valid;
  logic [63:0]       out_data;
  logic              out_end;
  logic              out_abort;

  int cyc      = 0;
  int last_cyc = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  int fr_tag [NP][8];
  int fr_nw  [NP][8];
  int fr_lb  [NP][8];
  int head   [NP] = '{default: 0};
  int tail   [NP] = '{default: 0};
  int widx   [NP] = '{default: 0};
  bit busy   [NP] = '{default: 1'b0};

  fabric_ingress_arbiter #(.NUM_PORTS(NP), .FWD_TIMEOUT(TIMEOUT), .HOLDOFF(2)) dut (
    .fabric_clk           (fabric_clk),
    .rst_n                (rst_n),
    .port_frame_valid     (port_frame_valid),
    .port_dst_mac         (port_dst_mac),
    .port_src_mac         (port_src_mac),
    .port_vlan            (port_vlan),
    .port_fwd_en          (port_fwd_en),
    .port_fwd_valid       (port_fwd_valid),
    .port_fwd_bytes_valid (port_fwd_bytes_valid),
    .port_fwd_data        (port_fwd_data),
    .port_pop             (port_pop),
    .out_ready            (out_ready),
    .out_start            (out_start),
    .out_port             (out_port),
    .out_dst_mac          (out_dst_mac),
    .out_src_mac          (out_src_mac),
    .out_vlan             (out_vlan),
    .out_valid            (out_valid),
    .out_bytes_valid      (out_bytes_valid),
    .out_data             (out_data),
    .out_end              (out_end),
    .out_abort            (out_abort)
  );

  always #5 fabric_clk = ~fabric_clk;
  always @(posedge fabric_clk) cyc <= cyc + 1;

  function automatic logic [63:0] word_data(input int p, input int t, input int i);
    return {16'hD0A7, 8'(p), 8'(t), 32'(i)};
  endfunction
  function automatic logic [47:0] dst_of(input int p, input int t);
    return {16'h0200, 8'(p), 8'(t), 16'hDD01};
  endfunction
  function automatic logic [47:0] src_of(input int p, input int t);
    return {16'h0A00, 8'(t), 8'(p), 16'h5502};
  endfunction
  function automatic logic [11:0] vlan_of(input int p, input int t);
    return 12'(256 + 16 * p + t);
  endfunction

  // Port model: per-port frame queue, one-cycle read latency after fwd_en
  always @(negedge fabric_clk) begin
    for (int i = 0; i < NP; i++) begin
      if (!rst_n) begin
        busy[i] = 1'b0;
      end else begin
        if (port_pop[i]) begin
          if (head[i] != tail[i]) head[i] = head[i] + 1;
          busy[i] = 1'b0;
        end
        if (port_fwd_en[i]) begin
          busy[i] = 1'b1;
          widx[i] = -1;
        end else if (busy[i]) begin
          widx[i] = widx[i] + 1;
        end
      end
      if (busy[i] && widx[i] >= 0 && widx[i] < fr_nw[i][head[i]]) begin
        port_fwd_valid[i]             = 1'b1;
        port_fwd_data[64*i +: 64]     = word_data(i, fr_tag[i][head[i]], widx[i]);
        port_fwd_bytes_valid[4*i +: 4] = (widx[i] == fr_nw[i][head[i]] - 1) ?
                                         4'(fr_lb[i][head[i]]) : 4'd8;
      end else begin
        port_fwd_valid[i]             = 1'b0;
        port_fwd_data[64*i +: 64]     = '0;
        port_fwd_bytes_valid[4*i +: 4] = '0;
        if (busy[i] && widx[i] >= fr_nw[i][head[i]]) busy[i] = 1'b0;
      end
      if (head[i] != tail[i]) begin
        port_frame_valid[i]     = 1'b1;
        port_dst_mac[48*i +: 48] = dst_of(i, fr_tag[i][head[i]]);
        port_src_mac[48*i +: 48] = src_of(i, fr_tag[i][head[i]]);
        port_vlan[12*i +: 12]    = vlan_of(i, fr_tag[i][head[i]]);
      end else begin
        port_frame_valid[i]     = 1'b0;
        port_dst_mac[48*i +: 48] = '0;
        port_src_mac[48*i +: 48] = '0;
        port_vlan[12*i +: 12]    = '0;
      end
    end
  end

  // Monitor: classify the cycle's DUT event and compare with the queue head
  int          m_n;
  int          m_kind;
  ev_t         m_e;
  bit          m_ok;
  logic [NP-1:0] m_oh;
  logic [3:0]  m_bytes;

  always @(negedge fabric_clk) begin
    if (rst_n) begin
      m_n    = 0;
      m_kind = -1;
      if (out_start || port_fwd_en != '0) begin m_kind = K_START; m_n++; end
      if (out_valid)                      begin m_kind = K_WORD;  m_n++; end
      if (out_end)                        begin m_kind = K_END;   m_n++; end
      if (out_abort)                      begin m_kind = K_ABORT; m_n++; end
      if (port_pop != '0)                 begin m_kind = K_POP;   m_n++; end
      if (m_n > 1) begin
        n_cmp++; n_fail++;
        $display("FAIL multi_event cyc=%0d: %0d events in one cycle, required 1", cyc, m_n);
      end else if (m_n == 1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected cyc=%0d: event kind %0d with empty scoreboard", cyc, m_kind);
        end else begin
          m_e  = sb.pop_front();
          m_oh = '0;
          m_oh[m_e.port] = 1'b1;
          m_ok = (m_kind == m_e.kind) && (out_port == 2'(m_e.port));
          if (m_ok) begin
            case (m_kind)
              K_START: m_ok = out_start && port_fwd_en == m_oh &&
                              out_dst_mac == dst_of(m_e.port, m_e.tag) &&
                              out_src_mac == src_of(m_e.port, m_e.tag) &&
                              out_vlan == vlan_of(m_e.port, m_e.tag);
              K_WORD: begin
                m_bytes = (m_e.idx == m_e.nw - 1) ? 4'(m_e.lb) : 4'd8;
                m_ok = out_data == word_data(m_e.port, m_e.tag, m_e.idx) &&
                       out_bytes_valid == m_bytes;
              end
              K_POP:   m_ok = port_pop == m_oh;
              default: m_ok = 1'b1;
            endcase
          end
          if (!m_ok) begin
            n_fail++;
            $display("FAIL event cyc=%0d: got kind=%0d port=%0d fwd_en=%b pop=%b data=%h bytes=%0d dst=%h vlan=%h, required kind=%0d port=%0d tag=%0d idx=%0d",
                     cyc, m_kind, out_port, port_fwd_en, port_pop, out_data, out_bytes_valid,
                     out_dst_mac, out_vlan, m_e.kind, m_e.port, m_e.tag, m_e.idx);
          end
          if (m_e.at >= 0) begin
            n_cmp++;
            if (cyc != m_e.at) begin
              n_fail++;
              $display("FAIL event_cycle kind=%0d port=%0d: got cycle %0d, required %0d",
                       m_e.kind, m_e.port, cyc, m_e.at);
            end
          end
          if (m_e.gap >= 0) begin
            n_cmp++;
            if (cyc - last_cyc != m_e.gap) begin
              n_fail++;
              $display("FAIL event_gap kind=%0d port=%0d: got %0d cycles, required %0d",
                       m_e.kind, m_e.port, cyc - last_cyc, m_e.gap);
            end
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push_ev(input int kind, input int p, input int t, input int idx,
                         input int nw, input int lb, input int gap, input int at);
    ev_t e;
    e.kind = kind; e.port = p; e.tag = t; e.idx = idx;
    e.nw = nw; e.lb = lb; e.gap = gap; e.at = at;
    sb.push_back(e);
  endtask

  // Whole-frame expectation; nw == 0 means the port never answers
  task automatic exp_frame(input int p, input int t, input int nw, input int lb,
                           input int at, input int gap);
    push_ev(K_START, p, t, 0, nw, lb, gap, at);
    if (nw == 0) begin
      push_ev(K_ABORT, p, t, 0, nw, lb, TIMEOUT, -1);
    end else begin
      for (int i = 0; i < nw; i++) push_ev(K_WORD, p, t, i, nw, lb, (i == 0) ? 2 : 1, -1);
      push_ev(K_END, p, t, 0, nw, lb, 1, -1);
    end
    push_ev(K_POP, p, t, 0, nw, lb, 1, -1);
  endtask

  task automatic add_frame(input int p, input int t, input int nw, input int lb);
    fr_tag[p][tail[p]] = t;
    fr_nw[p][tail[p]]  = nw;
    fr_lb[p][tail[p]]  = lb;
    tail[p] = tail[p] + 1;
  endtask

  task automatic drain(input string name, input int budget, input bit pad);
    for (int n = 0; n < budget && sb.size() != 0; n++) begin
      @(negedge fabric_clk);
      #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d events still pending, required 0", name, sb.size());
      sb.delete();
    end
    if (pad) begin
      repeat (4) @(posedge fabric_clk);
      #1;
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (|{port_fwd_en, port_pop, out_start, out_port, out_dst_mac, out_src_mac, out_vlan,
          out_valid, out_bytes_valid, out_data, out_end, out_abort}) begin
      n_fail++;
      $display("FAIL %s: fwd_en=%b pop=%b start=%b port=%0d valid=%b data=%h end=%b abort=%b, required all 0",
               name, port_fwd_en, port_pop, out_start, out_port, out_valid, out_data,
               out_end, out_abort);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge fabric_clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    @(posedge fabric_clk);
    #1;

    // All ports ready: rotation 0,1,2,3 then port 0's second frame
    add_frame(0, 0, 2, 8);
    add_frame(1, 0, 1, 1);
    add_frame(2, 0, 3, 5);
    add_frame(3, 0, 4, 8);
    add_frame(0, 1, 2, 3);
    exp_frame(0, 0, 2, 8, cyc + 1, -1);
    exp_frame(1, 0, 1, 1, -1, 3);
    exp_frame(2, 0, 3, 5, -1, 3);
    exp_frame(3, 0, 4, 8, -1, 3);
    exp_frame(0, 1, 2, 3, -1, 3);
    drain("all_ports", 300, 1'b1);

    // Single port 1, three words, last word 4 bytes
    add_frame(1, 1, 3, 4);
    exp_frame(1, 1, 3, 4, cyc + 1, -1);
    drain("single", 100, 1'b1);

    // out_ready low blocks grants; rr_ptr=2 then favours port 2 over port 1
    out_ready = 1'b0;
    add_frame(2, 1, 2, 8);
    add_frame(1, 2, 1, 2);
    repeat (10) @(posedge fabric_clk);
    #1;
    n_cmp++;
    if (port_fwd_en != '0 || out_start) begin
      n_fail++;
      $display("FAIL ready_block: fwd_en=%b start=%b, required 0 and 0", port_fwd_en, out_start);
    end
    out_ready = 1'b1;
    exp_frame(2, 1, 2, 8, cyc + 1, -1);
    exp_frame(1, 2, 1, 2, -1, 3);
    drain("ready", 100, 1'b1);

    // Reset mid-stream: outputs clear at once, no pop, frame re-granted
    add_frame(2, 2, 8, 8);
    push_ev(K_START, 2, 2, 0, 8, 8, -1, cyc + 1);
    for (int i = 0; i < 3; i++) push_ev(K_WORD, 2, 2, i, 8, 8, (i == 0) ? 2 : 1, -1);
    drain("pre_reset", 50, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge fabric_clk);
    #1;
    rst_n = 1'b1;
    exp_frame(2, 2, 8, 8, cyc + 1, -1);
    drain("post_reset", 100, 1'b1);

    // Port 0 stays ready with a second frame; port 1 must go between
    add_frame(0, 2, 1, 8);
    add_frame(0, 3, 2, 6);
    add_frame(1, 3, 2, 8);
    exp_frame(0, 2, 1, 8, cyc + 1, -1);
    exp_frame(1, 3, 2, 8, -1, 3);
    exp_frame(0, 3, 2, 6, -1, 3);
    drain("fairness", 200, 1'b1);

    // Port 3 granted but silent: abort after the timeout, then pop
    add_frame(3, 1, 0, 0);
    exp_frame(3, 1, 0, 0, cyc + 1, -1);
    drain("timeout", 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fabric_ingress_arbiter.md
# fabric_ingress_arbiter

Round-robin scheduler that shares the switch-fabric forwarding path among NUM_PORTS ingress RX FIFOs. It selects one port with a frame ready, latches that frame's headers, issues the fabric forward request, and streams the port's 64-bit data words onto a single output bus. When the frame ends it pops the frame from the port and rotates priority. It sits in the fabric_clk domain between the per-port RX FIFOs and the MAC-table/crossbar stage.

## Interface
- NUM_PORTS, 4: ingress ports arbitrated (2..16).
- FWD_TIMEOUT, 15: cycles allowed from fwd_en to first fwd_valid before abort.
- HOLDOFF, 2: idle cycles after pop, so the port's frame_valid can refresh.

- fabric_clk  in  1  fabric clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- port_frame_valid  in  NUM_PORTS  per-port frame ready.
- port_dst_mac  in  48*NUM_PORTS  per-port dst MAC; port i at [48i+47:48i]. Same packing applies to the other header buses.
- port_src_mac  in  48*NUM_PORTS  per-port src MAC.
- port_vlan  in  12*NUM_PORTS  per-port VLAN ID.
- port_fwd_en  out  NUM_PORTS  one-cycle, one-hot forward request.
- port_fwd_valid  in  NUM_PORTS  per-port data valid.
- port_fwd_bytes_valid  in  4*NUM_PORTS  valid bytes per word, 1..8.
- port_fwd_data  in  64*NUM_PORTS  per-port data word.
- port_pop  out  NUM_PORTS  one-cycle, one-hot frame pop.
- out_ready  in  1  downstream can accept a new frame. Sampled only in IDLE.
- out_start  out  1  one-cycle pulse; header outputs valid from this cycle until the next out_start.
- out_port  out  $clog2(NUM_PORTS)  source port of current frame.
- out_dst_mac / out_src_mac / out_vlan  out  48/48/12  latched headers.
- out_valid  out  1  data word valid.
- out_bytes_valid  out  4  valid bytes in out_data.
- out_data  out  64  frame data.
- out_end  out  1  one-cycle pulse; frame complete.
- out_abort  out  1  one-cycle pulse; frame aborted on timeout. Replaces out_end.

## Operation
- States: IDLE, WAIT, STREAM, POP, HOLD.
- IDLE, with out_ready=1 and any port_frame_valid set:
  - Search from port rr_ptr upward, modulo NUM_PORTS; pick the first valid port g.
  - Register port_fwd_en[g]=1, out_start=1, out_port=g and g's headers.
  - Go to WAIT and clear the timeout counter.
- IDLE with out_ready=0: no grant.
- WAIT:
  - port_fwd_valid[g]=1: forward the word (out_valid, out_bytes_valid, out_data) and go to STREAM.
  - Otherwise increment the counter. When it reaches FWD_TIMEOUT, assert out_abort and go to POP.
- STREAM:
  - Each cycle with port_fwd_valid[g]=1, forward the word.
  - First cycle with port_fwd_valid[g]=0: assert out_end and go to POP. Frames are contiguous; a gap ends the frame.
- POP: assert port_pop[g] for one cycle, set rr_ptr=(g+1) mod NUM_PORTS, go to HOLD.
- HOLD: wait HOLDOFF cycles, then go to IDLE.
- Inputs from ports other than g are ignored outside IDLE.
- A port_frame_valid[g] drop mid-frame is ignored.
- The counter saturates and never wraps.
- rr_ptr wraps from NUM_PORTS-1 to 0.

## Timing
- All outputs are registered.
- Reset: every output is 0; state=IDLE, rr_ptr=0, counter=0.
- Reset asserted mid-frame: immediate return to reset values. No pop is issued; the port retains its frame.
- Grant latency: port_frame_valid seen in IDLE at cycle t gives port_fwd_en and out_start at t+1.
- Data latency: port word at cycle t appears on out_* at t+1.
- out_end is asserted the cycle after the last out_valid. port_pop follows at out_end+1.
- Minimum gap from one out_start to the next out_start = frame words + 4 + HOLDOFF cycles.
- Simultaneous valid ports: lowest index at or above rr_ptr wins.
- out_valid is never asserted outside STREAM, or outside the single word accepted in WAIT.

## Test plan
- Single port 1, 3-word frame, last bytes_valid=4:
  - out_start at t+1, three out_valid words with bytes_valid 8, 8, 4.
  - out_end after the last word, then port_pop=4'b0010.
  - rr_ptr becomes 2.
- All 4 ports valid continuously: grant order 0,1,2,3,0. Each port_pop is one-hot and matches out_port.
- out_ready=0 with port 2 valid for 10 cycles: no fwd_en. Raising out_ready gives fwd_en[2] next cycle.
- Port 3 granted, never asserts fwd_valid: out_abort 15 cycles after fwd_en, then port_pop[3]; no out_valid.
- rst_n pulsed low during STREAM: all outputs 0 asynchronously, no pop. After release, the same port is re-granted from rr_ptr=0 priority.
- Port 0 frame_valid held high with port 1 also valid: after port 0 pops, port 1 is granted before port 0.
